mem_port_arbiter: RTL

- Shares the single 16-bit memory port between the instruction-fetch stage and the data-access stage.
- Accepts one request at a time and drives the memory address, enable and write data.
- Waits a fixed memory latency, then returns read data with a one-cycle acknowledge to the granted requester.
- Data accesses have priority over fetch; an optional guard bounds how long fetch can be starved.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access.
// Optional macro ARB_STARVE_GUARD_EN bounds fetch starvation to MAX_WAIT.
module mem_port_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IF_REQ,
   input  logic [AW-1:0] IF_ADDR,
   output logic          IF_ACK,
   output logic [DW-1:0] IF_RDATA,
   input  logic          D_REQ,
   input  logic          D_WE,
   input  logic [AW-1:0] D_ADDR,
   input  logic [DW-1:0] D_WDATA,
   output logic          D_ACK,
   output logic [DW-1:0] D_RDATA,
   output logic [AW-1:0] MEM_ADDR,
   output logic          MEM_RE,
   output logic          MEM_WE,
   output logic [DW-1:0] MEM_WDATA,
   input  logic [DW-1:0] MEM_RDATA,
   output logic          ARB_BUSY
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [3:0] LAT4   = 4'(MEM_LAT);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          owner_q, owner_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          re_q, re_d;
   logic          we_q, we_d;
   logic          if_ack_q, if_ack_d;
   logic          d_ack_q, d_ack_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          force_f;
   logic          grant_f;
   logic          grant_d;

   // owner_q: 1 = data access, 0 = fetch
   assign grant_f = IF_REQ && (!D_REQ || force_f);
   assign grant_d = D_REQ && !grant_f;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] MAXW = 4'(MAX_WAIT);
   logic [3:0] wait_q, wait_d;

   assign force_f = (wait_q == MAXW);

   // count data grants that bypass a pending fetch, saturating at MAXW
   always_comb begin
      wait_d = wait_q;
      if (state_q == S_IDLE) begin
         if (!IF_REQ || grant_f)
            wait_d = '0;
         else if (grant_d && wait_q != MAXW)
            wait_d = wait_q + 4'd1;
      end
   end

   // wait counter register
   always_ff @(posedge CLK) begin
      if (RST) wait_q <= '0;
      else     wait_q <= wait_d;
   end
`else
   assign force_f = 1'b0;
`endif

   // arbitration, latency countdown and read-data capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      re_d       = re_q;
      we_d       = we_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_d) begin
               owner_d = 1'b1;
               wr_d    = D_WE;
               addr_d  = D_ADDR;
               wdata_d = D_WDATA;
               re_d    = !D_WE;
               we_d    = D_WE;
               cnt_d   = LAT4;
               state_d = S_BUSY;
            end else if (grant_f) begin
               owner_d = 1'b0;
               wr_d    = 1'b0;
               addr_d  = IF_ADDR;
               re_d    = 1'b1;
               we_d    = 1'b0;
               cnt_d   = LAT4;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            we_d  = 1'b0;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               re_d    = 1'b0;
               state_d = S_DONE;
               if (owner_q) begin
                  d_ack_d = 1'b1;
                  if (!wr_q) d_rdata_d = MEM_RDATA;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = MEM_RDATA;
               end
            end
         end
         S_DONE: begin
            re_d    = 1'b0;
            we_d    = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            re_d    = 1'b0;
            we_d    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         owner_q    <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         re_q       <= 1'b0;
         we_q       <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         re_q       <= re_d;
         we_q       <= we_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign IF_ACK    = if_ack_q;
   assign IF_RDATA  = if_rdata_q;
   assign D_ACK     = d_ack_q;
   assign D_RDATA   = d_rdata_q;
   assign MEM_ADDR  = addr_q;
   assign MEM_RE    = re_q;
   assign MEM_WE    = we_q;
   assign MEM_WDATA = wdata_q;
   assign ARB_BUSY  = (state_q != S_IDLE);

endmodule
